// File: rtl/physicaloid_scif_stream_bridge.sv
// physicaloid_scif_stream_bridge
//   Single-clock bridge between Avalon-ST byte streams and the Physicaloid
//   serial interface (SCIF). The host-driven scif_sclk is oversampled in the
//   clk domain, and all serial activity happens on its synchronised edges.
// Ports
//   clk, reset        : system clock, synchronous active-high reset
//   out_*             : Avalon-ST source fed by the SCIF->Avalon FIFO (infifo)
//   in_*              : Avalon-ST sink feeding the Avalon->SCIF FIFO (outfifo)
//   scif_sclk/txd     : host serial clock and host->FPGA data
//   scif_txr_n        : FPGA ready to receive (active low), updated on sclk fall
//   scif_rxd          : FPGA->host data, updated on sclk fall
//   scif_rxr_n        : host ready to receive (active low)
//   stat_framing_err  : 1-clk pulse, bad stop bit, byte dropped
//   stat_overrun      : 1-clk pulse, good byte dropped because infifo is full
//   in_level          : infifo occupancy
module physicaloid_scif_stream_bridge #(
  parameter int DATA_BITS      = 8,
  parameter int IN_DEPTH_LOG2  = 4,
  parameter int OUT_DEPTH_LOG2 = 4,
  parameter int TXR_MARGIN     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_BITS-1:0]     out_data,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [DATA_BITS-1:0]     in_data,
  input  logic                     scif_sclk,
  input  logic                     scif_txd,
  output logic                     scif_txr_n,
  output logic                     scif_rxd,
  input  logic                     scif_rxr_n,
  output logic                     stat_framing_err,
  output logic                     stat_overrun,
  output logic [IN_DEPTH_LOG2:0]   in_level
);

  localparam int IN_DEPTH  = 2 ** IN_DEPTH_LOG2;
  localparam int OUT_DEPTH = 2 ** OUT_DEPTH_LOG2;
  localparam int CNT_W     = $clog2(DATA_BITS + 1);
  localparam logic [IN_DEPTH_LOG2:0]  IN_DEPTH_C  = (IN_DEPTH_LOG2 + 1)'(IN_DEPTH);
  localparam logic [IN_DEPTH_LOG2:0]  MARGIN_C    = (IN_DEPTH_LOG2 + 1)'(TXR_MARGIN);
  localparam logic [OUT_DEPTH_LOG2:0] OUT_DEPTH_C = (OUT_DEPTH_LOG2 + 1)'(OUT_DEPTH);
  localparam logic [CNT_W-1:0]        LAST_BIT_C  = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_DATA = 2'd1, RX_STOP = 2'd2} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_DATA = 2'd1, TX_STOP = 2'd2} tx_state_t;

  // ---------------- synchronisers and edge detection ----------------
  logic [1:0] sclk_sync_r, txd_sync_r, rxr_sync_r;
  logic       sclk_dly_r;
  logic       sclk_rise_s, sclk_fall_s, txd_s, rxr_s;

  // Two-flop synchronisers plus one delay stage for sclk edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_r <= 2'b11;
      txd_sync_r  <= 2'b11;
      rxr_sync_r  <= 2'b11;
      sclk_dly_r  <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[0], scif_sclk};
      txd_sync_r  <= {txd_sync_r[0], scif_txd};
      rxr_sync_r  <= {rxr_sync_r[0], scif_rxr_n};
      sclk_dly_r  <= sclk_sync_r[1];
    end
  end

  assign sclk_rise_s = sclk_sync_r[1] & ~sclk_dly_r;
  assign sclk_fall_s = ~sclk_sync_r[1] & sclk_dly_r;
  assign txd_s       = txd_sync_r[1];
  assign rxr_s       = rxr_sync_r[1];

  // ---------------- infifo (SCIF -> Avalon) ----------------
  logic [DATA_BITS-1:0]     in_mem_r [IN_DEPTH];
  logic [IN_DEPTH_LOG2-1:0] in_wr_ptr_r, in_rd_ptr_r;
  logic [IN_DEPTH_LOG2:0]   in_count_r;
  logic                     in_full_s, in_pop_s;

  // ---------------- deserialiser ----------------
  rx_state_t            rx_state_r, rx_state_nxt_s;
  logic [CNT_W-1:0]     rx_cnt_r;
  logic [DATA_BITS-1:0] rx_shreg_r;
  logic [DATA_BITS:0]   rx_cat_s;
  logic                 rx_clr_s, rx_shift_s, rx_push_s, rx_ovr_s, rx_ferr_s;
  logic                 ferr_r, ovr_r, txr_n_r;

  assign rx_cat_s = {txd_s, rx_shreg_r};

  // Deserialiser state register
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_r <= RX_IDLE;
    end else begin
      rx_state_r <= rx_state_nxt_s;
    end
  end

  // Deserialiser next state; every STOP outcome is exactly one of push/overrun/framing
  always_comb begin
    rx_state_nxt_s = rx_state_r;
    rx_clr_s       = 1'b0;
    rx_shift_s     = 1'b0;
    rx_push_s      = 1'b0;
    rx_ovr_s       = 1'b0;
    rx_ferr_s      = 1'b0;
    if (sclk_rise_s) begin
      case (rx_state_r)
        RX_IDLE: begin
          if (!txd_s) begin
            rx_state_nxt_s = RX_DATA;
            rx_clr_s       = 1'b1;
          end else begin
            rx_state_nxt_s = RX_IDLE;
          end
        end
        RX_DATA: begin
          rx_shift_s = 1'b1;
          if (rx_cnt_r == LAST_BIT_C) begin
            rx_state_nxt_s = RX_STOP;
          end else begin
            rx_state_nxt_s = RX_DATA;
          end
        end
        RX_STOP: begin
          rx_state_nxt_s = RX_IDLE;
          if (!txd_s) begin
            rx_ferr_s = 1'b1;
          end else if (in_full_s) begin
            rx_ovr_s = 1'b1;
          end else begin
            rx_push_s = 1'b1;
          end
        end
        default: rx_state_nxt_s = RX_IDLE;
      endcase
    end else begin
      rx_state_nxt_s = rx_state_r;
    end
  end

  // Deserialiser shift register (LSB arrives first) and bit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cnt_r   <= '0;
      rx_shreg_r <= '0;
    end else if (rx_clr_s) begin
      rx_cnt_r <= '0;
    end else if (rx_shift_s) begin
      rx_shreg_r <= rx_cat_s[DATA_BITS:1];
      rx_cnt_r   <= rx_cnt_r + CNT_W'(1);
    end
  end

  // Status pulses, one clk wide
  always_ff @(posedge clk) begin
    if (reset) begin
      ferr_r <= 1'b0;
      ovr_r  <= 1'b0;
    end else begin
      ferr_r <= rx_ferr_s;
      ovr_r  <= rx_ovr_s;
    end
  end

  assign in_full_s = (in_count_r == IN_DEPTH_C);
  assign out_valid = (in_count_r != '0);
  assign in_pop_s  = out_valid & out_ready;

  // infifo storage; emptied logically by pointer reset
  always_ff @(posedge clk) begin
    if (rx_push_s) begin
      in_mem_r[in_wr_ptr_r] <= rx_shreg_r;
    end
  end

  // infifo pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      in_wr_ptr_r <= '0;
      in_rd_ptr_r <= '0;
      in_count_r  <= '0;
    end else begin
      if (rx_push_s) in_wr_ptr_r <= in_wr_ptr_r + IN_DEPTH_LOG2'(1);
      if (in_pop_s)  in_rd_ptr_r <= in_rd_ptr_r + IN_DEPTH_LOG2'(1);
      if (rx_push_s && !in_pop_s) begin
        in_count_r <= in_count_r + (IN_DEPTH_LOG2 + 1)'(1);
      end else if (in_pop_s && !rx_push_s) begin
        in_count_r <= in_count_r - (IN_DEPTH_LOG2 + 1)'(1);
      end
    end
  end

  // TXR is ready while free entries exceed the margin; changes only on sclk fall
  always_ff @(posedge clk) begin
    if (reset) begin
      txr_n_r <= 1'b1;
    end else if (sclk_fall_s) begin
      txr_n_r <= ~((IN_DEPTH_C - in_count_r) > MARGIN_C);
    end
  end

  // ---------------- outfifo (Avalon -> SCIF) ----------------
  logic [DATA_BITS-1:0]      out_mem_r [OUT_DEPTH];
  logic [OUT_DEPTH_LOG2-1:0] out_wr_ptr_r, out_rd_ptr_r;
  logic [OUT_DEPTH_LOG2:0]   out_count_r, out_count_nxt_s;
  logic                      out_push_s, out_pop_s, in_ready_r;

  assign out_push_s = in_valid & in_ready_r;

  // Next outfifo occupancy, used so in_ready is registered yet exact
  always_comb begin
    out_count_nxt_s = out_count_r;
    if (out_push_s && !out_pop_s) begin
      out_count_nxt_s = out_count_r + (OUT_DEPTH_LOG2 + 1)'(1);
    end else if (out_pop_s && !out_push_s) begin
      out_count_nxt_s = out_count_r - (OUT_DEPTH_LOG2 + 1)'(1);
    end else begin
      out_count_nxt_s = out_count_r;
    end
  end

  // outfifo storage
  always_ff @(posedge clk) begin
    if (out_push_s) begin
      out_mem_r[out_wr_ptr_r] <= in_data;
    end
  end

  // outfifo pointers, occupancy and sink ready
  always_ff @(posedge clk) begin
    if (reset) begin
      out_wr_ptr_r <= '0;
      out_rd_ptr_r <= '0;
      out_count_r  <= '0;
      in_ready_r   <= 1'b0;
    end else begin
      if (out_push_s) out_wr_ptr_r <= out_wr_ptr_r + OUT_DEPTH_LOG2'(1);
      if (out_pop_s)  out_rd_ptr_r <= out_rd_ptr_r + OUT_DEPTH_LOG2'(1);
      out_count_r <= out_count_nxt_s;
      in_ready_r  <= (out_count_nxt_s != OUT_DEPTH_C);
    end
  end

  // ---------------- serialiser ----------------
  tx_state_t            tx_state_r, tx_state_nxt_s;
  logic [CNT_W-1:0]     tx_cnt_r;
  logic [DATA_BITS-1:0] tx_shreg_r;
  logic                 tx_shift_s, tx_stop_s, rxd_r;

  // Serialiser state register
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_r <= TX_IDLE;
    end else begin
      tx_state_r <= tx_state_nxt_s;
    end
  end

  // Serialiser next state; host readiness is only consulted between frames
  always_comb begin
    tx_state_nxt_s = tx_state_r;
    out_pop_s      = 1'b0;
    tx_shift_s     = 1'b0;
    tx_stop_s      = 1'b0;
    if (sclk_fall_s) begin
      case (tx_state_r)
        TX_IDLE: begin
          if ((out_count_r != '0) && !rxr_s) begin
            tx_state_nxt_s = TX_DATA;
            out_pop_s      = 1'b1;
          end else begin
            tx_state_nxt_s = TX_IDLE;
          end
        end
        TX_DATA: begin
          tx_shift_s = 1'b1;
          if (tx_cnt_r == LAST_BIT_C) begin
            tx_state_nxt_s = TX_STOP;
          end else begin
            tx_state_nxt_s = TX_DATA;
          end
        end
        TX_STOP: begin
          tx_stop_s      = 1'b1;
          tx_state_nxt_s = TX_IDLE;
        end
        default: tx_state_nxt_s = TX_IDLE;
      endcase
    end else begin
      tx_state_nxt_s = tx_state_r;
    end
  end

  // Serialiser datapath: start bit on pop, then LSB-first data, then stop bit
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_r      <= 1'b1;
      tx_cnt_r   <= '0;
      tx_shreg_r <= '0;
    end else if (out_pop_s) begin
      rxd_r      <= 1'b0;
      tx_cnt_r   <= '0;
      tx_shreg_r <= out_mem_r[out_rd_ptr_r];
    end else if (tx_shift_s) begin
      rxd_r      <= tx_shreg_r[0];
      tx_shreg_r <= tx_shreg_r >> 1;
      tx_cnt_r   <= tx_cnt_r + CNT_W'(1);
    end else if (tx_stop_s) begin
      rxd_r <= 1'b1;
    end
  end

  assign out_data         = in_mem_r[in_rd_ptr_r];
  assign in_ready         = in_ready_r;
  assign scif_txr_n       = txr_n_r;
  assign scif_rxd         = rxd_r;
  assign stat_framing_err = ferr_r;
  assign stat_overrun     = ovr_r;
  assign in_level         = in_count_r;

endmodule

// File: tb/tb_physicaloid_scif_stream_bridge.sv
// Testbench for physicaloid_scif_stream_bridge: directed host-side stimulus
// with scoreboard queues for bytes expected on the Avalon source and frames
// expected on scif_rxd.
module tb_physicaloid_scif_stream_bridge;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       out_ready = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       scif_sclk = 1'b1;
  logic       scif_txd = 1'b1;
  logic       scif_rxr_n = 1'b1;
  logic       out_valid, in_ready, scif_txr_n, scif_rxd;
  logic       stat_framing_err, stat_overrun;
  logic [7:0] out_data;
  logic [4:0] in_level;

  physicaloid_scif_stream_bridge dut (
    .clk(clk), .reset(reset),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .scif_sclk(scif_sclk), .scif_txd(scif_txd), .scif_txr_n(scif_txr_n),
    .scif_rxd(scif_rxd), .scif_rxr_n(scif_rxr_n),
    .stat_framing_err(stat_framing_err), .stat_overrun(stat_overrun),
    .in_level(in_level)
  );

  always #5 clk = ~clk;
  always #40 scif_sclk = ~scif_sclk;   // sclk = clk/8

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] rx_q[$];
  logic [9:0] tx_q[$];
  int model_level = 0;
  int rd_idx = 0;

  // status pulse monitors: cycles high and rising edges
  int ferr_hi = 0, ferr_rise = 0, ovr_hi = 0, ovr_rise = 0;
  logic ferr_prev = 1'b0, ovr_prev = 1'b0;
  time last_reset_t = 0;
  always @(negedge clk) begin
    if (stat_framing_err === 1'b1) ferr_hi <= ferr_hi + 1;
    if (stat_framing_err === 1'b1 && !ferr_prev) ferr_rise <= ferr_rise + 1;
    if (stat_overrun === 1'b1) ovr_hi <= ovr_hi + 1;
    if (stat_overrun === 1'b1 && !ovr_prev) ovr_rise <= ovr_rise + 1;
    ferr_prev <= (stat_framing_err === 1'b1);
    ovr_prev  <= (stat_overrun === 1'b1);
    if (reset) last_reset_t <= $time;
  end

  // host-side receiver of scif_rxd, sampling on sclk rise
  logic [9:0] got_frames [32];
  int   got_cnt = 0;
  int   mon_cnt = 0;
  logic mon_active = 1'b0;
  logic [9:0] mon_frame = 10'h000;
  time  mon_start_t = 0;
  always @(posedge scif_sclk) begin
    if (mon_active && (last_reset_t > mon_start_t)) begin
      mon_active <= 1'b0;
    end else if (!mon_active) begin
      if (scif_rxd === 1'b0) begin
        mon_active  <= 1'b1;
        mon_cnt     <= 1;
        mon_frame   <= 10'h000;
        mon_start_t <= $time;
      end
    end else begin
      mon_frame[mon_cnt] <= scif_rxd;
      if (mon_cnt == 9) begin
        got_frames[got_cnt % 32] <= {scif_rxd, mon_frame[8:0]};
        got_cnt    <= got_cnt + 1;
        mon_active <= 1'b0;
      end else begin
        mon_cnt <= mon_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [9:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge scif_sclk);
      #1 scif_txd = frame[i];
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bits({stop, b, 1'b0}, 10);
    @(negedge scif_sclk);
    #1 scif_txd = 1'b1;
    if (stop && model_level < 16) begin
      rx_q.push_back(b);
      model_level++;
    end
  endtask

  task automatic read_byte(input string tag);
    int t;
    logic [7:0] exp;
    t = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_q_nonempty"}, rx_q.size() > 0, 1);
    exp = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
    check({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    model_level--;
  endtask

  task automatic push_tx(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("tx_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    tx_q.push_back({1'b1, b, 1'b0});
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (got_cnt < n && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("frames_seen", got_cnt >= n, 1);
  endtask

  task automatic cmp_frames();
    while (tx_q.size() > 0 && rd_idx < got_cnt) begin
      check("tx_frame", got_frames[rd_idx % 32], tx_q.pop_front());
      rd_idx++;
    end
    check("tx_q_drained", tx_q.size(), 0);
  endtask

  int t_wait;
  int got_before, ferr_before, ovr_before;

  initial begin
    // T1 reset values
    repeat (3) @(negedge clk);
    check("rst_txr_n", scif_txr_n, 1);
    check("rst_rxd", scif_rxd, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_in_level", in_level, 0);
    check("rst_stats", {stat_framing_err, stat_overrun}, 0);
    reset = 1'b0;
    @(negedge scif_sclk);
    repeat (4) @(negedge clk);
    check("post_rst_txr_n", scif_txr_n, 0);
    check("post_rst_in_ready", in_ready, 1);

    // T2 receive 0xA5
    send_frame(8'hA5, 1'b1);
    read_byte("t2");
    check("t2_valid_drop", out_valid, 0);
    check("t2_level", in_level, 0);

    // T3 framing error on 0x3C
    send_frame(8'h3C, 1'b0);
    repeat (4) @(negedge clk);
    check("t3_ferr_cycles", ferr_hi, 1);
    check("t3_ferr_pulses", ferr_rise, 1);
    check("t3_out_valid", out_valid, 0);
    check("t3_level", in_level, 0);
    check("t3_ovr", ovr_hi, 0);

    // T4 fill infifo, TXR backpressure, overrun on 17th byte
    for (int k = 1; k <= 16; k++) begin
      send_frame(8'((k * 29 + 3) & 255), 1'b1);
      repeat (4) @(negedge clk);
      check("t4_level", in_level, model_level);
      check("t4_txr_n", scif_txr_n, (k >= 14) ? 1 : 0);
    end
    send_frame(8'hEE, 1'b1);
    repeat (4) @(negedge clk);
    check("t4_ovr_cycles", ovr_hi, 1);
    check("t4_ovr_pulses", ovr_rise, 1);
    check("t4_level_full", in_level, 16);
    check("t4_no_ferr", ferr_hi, 1);
    for (int k = 0; k < 16; k++) read_byte("t4_drain");
    check("t4_level_empty", in_level, 0);

    // T5 transmit 0x5A, 0x81 with a host hold between them
    push_tx(8'h5A);
    push_tx(8'h81);
    repeat (24) @(negedge clk);
    check("t5_rxd_idle_hold", scif_rxd, 1);
    scif_rxr_n = 1'b0;
    t_wait = 0;
    while (!mon_active && t_wait < 200) begin
      @(negedge clk);
      t_wait++;
    end
    check("t5_frame_started", mon_active, 1);
    scif_rxr_n = 1'b1;
    wait_frames(1);
    repeat (48) @(negedge clk);
    check("t5_hold_count", got_cnt, 1);
    check("t5_hold_rxd", scif_rxd, 1);
    scif_rxr_n = 1'b0;
    wait_frames(2);
    cmp_frames();

    // T6 reset in the middle of an outgoing and an incoming frame
    got_before  = got_cnt;
    ferr_before = ferr_hi;
    ovr_before  = ovr_hi;
    push_tx(8'h69);
    void'(tx_q.pop_back());
    send_bits({1'b1, 8'h96, 1'b0}, 5);
    reset    = 1'b1;
    scif_txd = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_rst_rxd", scif_rxd, 1);
    reset = 1'b0;
    repeat (24) @(negedge clk);
    check("t6_rxd", scif_rxd, 1);
    check("t6_level", in_level, 0);
    check("t6_out_valid", out_valid, 0);
    check("t6_no_frame", got_cnt, got_before);
    check("t6_no_ferr", ferr_hi, ferr_before);
    check("t6_no_ovr", ovr_hi, ovr_before);
    send_frame(8'hC3, 1'b1);
    read_byte("t6_rx");
    push_tx(8'h96);
    wait_frames(got_before + 1);
    cmp_frames();
    check("t6_final_ferr", ferr_hi, ferr_before);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
